// File: rtl/npc_axi_pkg.sv
// Shared AXI-lite definitions: arbiter FSM state encoding and response codes.
package npc_axi_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD0  = 2'd1;
  localparam state_t ST_RD1  = 2'd2;
  localparam state_t ST_WR1  = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-lite arbiter: m0 read-only (ifetch), m1 read/write (load/store),
// one transaction at a time onto a single shared slave port.
module axi_lite_arbiter
  import npc_axi_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0 read
  input  logic [ADDR_W-1:0]     m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_W-1:0]     m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  // master 1 read
  input  logic [ADDR_W-1:0]     m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_W-1:0]     m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  // master 1 write
  input  logic [ADDR_W-1:0]     m1_awaddr,
  input  logic                  m1_awvalid,
  output logic                  m1_awready,
  input  logic [DATA_W-1:0]     m1_wdata,
  input  logic [DATA_W/8-1:0]   m1_wstrb,
  input  logic                  m1_wvalid,
  output logic                  m1_wready,
  output logic [1:0]            m1_bresp,
  output logic                  m1_bvalid,
  input  logic                  m1_bready,
  // shared slave
  output logic [ADDR_W-1:0]     s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_W-1:0]     s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [ADDR_W-1:0]     s_awaddr,
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [DATA_W-1:0]     s_wdata,
  output logic [DATA_W/8-1:0]   s_wstrb,
  output logic                  s_wvalid,
  input  logic                  s_wready,
  input  logic [1:0]            s_bresp,
  input  logic                  s_bvalid,
  output logic                  s_bready
);

  state_t state_q, state_d;
  logic   last_m1_q, last_m1_d;
  logic   ar_done_q, ar_done_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q,  w_done_d;

  logic req0, req1r, req1w, req1;
  logic grant_m0;
  logic b_ok;

  assign req0     = m0_arvalid;
  assign req1r    = m1_arvalid;
  assign req1w    = m1_awvalid | m1_wvalid;
  assign req1     = req1r | req1w;
  assign grant_m0 = req0 & (~req1 | last_m1_q);
  assign b_ok     = aw_done_q & w_done_q;

  // Output mux keyed on state; R/B from the slave are masked until the address
  // handshake so an early response from a misbehaving slave is ignored.
  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    s_awaddr   = '0;
    s_awvalid  = 1'b0;
    s_wdata    = '0;
    s_wstrb    = '0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m0_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rvalid  = 1'b0;
    m1_awready = 1'b0;
    m1_wready  = 1'b0;
    m1_bvalid  = 1'b0;
    m0_rdata   = s_rdata;
    m0_rresp   = s_rresp;
    m1_rdata   = s_rdata;
    m1_rresp   = s_rresp;
    m1_bresp   = s_bresp;
    case (state_q)
      ST_RD0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid & ~ar_done_q;
        m0_arready = s_arready & ~ar_done_q;
        m0_rvalid  = s_rvalid & ar_done_q;
        s_rready   = m0_rready & ar_done_q;
      end
      ST_RD1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid & ~ar_done_q;
        m1_arready = s_arready & ~ar_done_q;
        m1_rvalid  = s_rvalid & ar_done_q;
        s_rready   = m1_rready & ar_done_q;
      end
      ST_WR1: begin
        s_awaddr   = m1_awaddr;
        s_awvalid  = m1_awvalid & ~aw_done_q;
        m1_awready = s_awready & ~aw_done_q;
        s_wdata    = m1_wdata;
        s_wstrb    = m1_wstrb;
        s_wvalid   = m1_wvalid & ~w_done_q;
        m1_wready  = s_wready & ~w_done_q;
        m1_bvalid  = s_bvalid & b_ok;
        s_bready   = m1_bready & b_ok;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    ar_done_d = ar_done_q | (s_arvalid & s_arready);
    aw_done_d = aw_done_q | (s_awvalid & s_awready);
    w_done_d  = w_done_q  | (s_wvalid & s_wready);
    case (state_q)
      ST_IDLE: begin
        if (grant_m0) begin
          state_d   = ST_RD0;
          last_m1_d = 1'b0;
        end else if (req1) begin
          state_d   = req1w ? ST_WR1 : ST_RD1;
          last_m1_d = 1'b1;
        end
      end
      ST_RD0, ST_RD1: if (s_rvalid & s_rready) state_d = ST_IDLE;
      ST_WR1:         if (s_bvalid & s_bready) state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
    if (state_d == ST_IDLE) begin
      ar_done_d = 1'b0;
      aw_done_d = 1'b0;
      w_done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      last_m1_q <= 1'b1;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter; the bench itself plays the shared slave.
module tb_axi_lite_arbiter;
  import npc_axi_pkg::*;

  logic        clk, rst;
  logic [31:0] m0_araddr, m1_araddr, m1_awaddr, m1_wdata;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_rdata, m1_rdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp;
  logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
  logic [3:0]  m1_wstrb, s_wstrb;
  logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
  logic [1:0]  s_rresp, s_bresp;
  logic        s_arvalid, s_arready, s_rvalid, s_rready;
  logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;

  int n_cmp = 0;
  int n_fail = 0;

  axi_lite_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
    .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
    .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string name);
    chk(name, {20'd0, m0_arready, m0_rvalid, m1_arready, m1_rvalid, m1_awready, m1_wready,
               m1_bvalid, s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}, 32'd0);
  endtask

  // Called at a negedge with the arbiter idle; returns at the negedge after the R handshake.
  task automatic do_read(input bit m, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] resp, input int lat,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    if (m) begin m1_arvalid = 1'b1; m1_araddr = addr; m1_rready = 1'b1; end
    else   begin m0_arvalid = 1'b1; m0_araddr = addr; m0_rready = 1'b1; end
    #1 chk("rd_arb_latency", {31'd0, s_arvalid}, 32'd0);
    @(negedge clk);
    s_arready = 1'b1;
    s_rvalid  = 1'b1;           // premature R must be ignored
    s_rdata   = 32'hBAD0BAD0;
    #1;
    chk("rd_s_arvalid", {31'd0, s_arvalid}, 32'd1);
    chk("rd_s_araddr", s_araddr, addr);
    chk("rd_arready", {31'd0, (m ? m1_arready : m0_arready)}, 32'd1);
    chk("rd_other_arready", {31'd0, (m ? m0_arready : m1_arready)}, 32'd0);
    chk("rd_early_r", {30'd0, m0_rvalid, m1_rvalid | s_rready}, 32'd0);
    @(negedge clk);
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    if (m) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
    #1 chk("rd_ar_once", {31'd0, s_arvalid}, 32'd0);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      #1 chk("rd_wait_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    end
    s_rvalid = 1'b1;
    s_rdata  = data;
    s_rresp  = resp;
    #1;
    chk("rd_rdata", m ? m1_rdata : m0_rdata, exp_data);
    chk("rd_rresp", {30'd0, (m ? m1_rresp : m0_rresp)}, {30'd0, exp_resp});
    chk("rd_rvalid", {30'd0, m0_rvalid, m1_rvalid}, m ? 32'd1 : 32'd2);
    chk("rd_s_rready", {31'd0, s_rready}, 32'd1);
    @(negedge clk);
    s_rvalid = 1'b0;
    #1;
    chk("rd_back_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    chk("rd_rvalid_low", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
  endtask

  // W is accepted 'lead' cycles before AW (0 = same cycle).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] resp, input int lead, input logic [1:0] exp_resp);
    m1_awaddr = addr; m1_awvalid = 1'b1;
    m1_wdata = data;  m1_wstrb = strb; m1_wvalid = 1'b1; m1_bready = 1'b1;
    #1 chk("wr_arb_latency", {30'd0, s_awvalid, s_wvalid}, 32'd0);
    @(negedge clk);
    s_wready  = 1'b1;
    s_awready = (lead == 0);
    s_bvalid  = 1'b1;           // premature B must be ignored
    s_bresp   = resp;
    #1;
    chk("wr_valids", {30'd0, s_awvalid, s_wvalid}, 32'd3);
    chk("wr_s_awaddr", s_awaddr, addr);
    chk("wr_s_wdata", s_wdata, data);
    chk("wr_s_wstrb", {28'd0, s_wstrb}, {28'd0, strb});
    chk("wr_no_ar", {31'd0, s_arvalid}, 32'd0);
    chk("wr_wready", {31'd0, m1_wready}, 32'd1);
    chk("wr_early_b", {30'd0, m1_bvalid, s_bready}, 32'd0);
    @(negedge clk);
    m1_wvalid = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    if (lead > 0) begin
      for (int k = 1; k < lead; k++) begin
        #1 chk("wr_w_gap", {30'd0, s_awvalid, s_wvalid}, 32'd2);
        @(negedge clk);
      end
      s_awready = 1'b1;
      #1 chk("wr_awready", {31'd0, m1_awready}, 32'd1);
      @(negedge clk);
    end
    m1_awvalid = 1'b0; s_awready = 1'b0;
    #1 chk("wr_after_hs", {30'd0, s_awvalid, s_wvalid}, 32'd0);
    s_bvalid = 1'b1;
    s_bresp  = resp;
    #1;
    chk("wr_bvalid", {30'd0, m1_bvalid, s_bready}, 32'd3);
    chk("wr_bresp", {30'd0, m1_bresp}, {30'd0, exp_resp});
    chk("wr_no_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    @(negedge clk);
    s_bvalid = 1'b0; m1_bready = 1'b0;
    #1;
    chk("wr_back_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    chk("wr_bvalid_low", {31'd0, m1_bvalid}, 32'd0);
  endtask

  typedef struct {
    bit          wr;
    bit          m;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    int          lat;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h8000_0000, 32'h0000_0413, 4'h0, RESP_OKAY,   2, 32'h0000_0413, 2'b00};
    vecs[1] = '{1'b0, 1'b1, 32'h1000_0040, 32'hCAFE_F00D, 4'h0, RESP_SLVERR, 1, 32'hCAFE_F00D, 2'b10};
    vecs[2] = '{1'b1, 1'b1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, RESP_OKAY, 3, 32'h0, 2'b00};
    vecs[3] = '{1'b1, 1'b1, 32'h2000_0008, 32'h1234_5678, 4'b1111, RESP_SLVERR, 0, 32'h0, 2'b10};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0000, 32'hFFFF_FFFF, 4'h0, RESP_OKAY,   3, 32'hFFFF_FFFF, 2'b00};

    rst = 1'b1;
    m0_araddr = '0; m0_arvalid = 1'b1; m0_rready = 1'b1;
    m1_araddr = '0; m1_arvalid = 1'b0; m1_rready = 1'b0;
    m1_awaddr = '0; m1_awvalid = 1'b1; m1_wdata = '0; m1_wstrb = '0; m1_wvalid = 1'b0; m1_bready = 1'b1;
    s_arready = 1'b1; s_rdata = '0; s_rresp = '0; s_rvalid = 1'b1;
    s_awready = 1'b1; s_wready = 1'b1; s_bresp = '0; s_bvalid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1 chk_quiet("reset_quiet");
    chk("reset_state", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    m0_arvalid = 1'b0; m1_awvalid = 1'b0; m1_bready = 1'b0; m0_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // both masters read together after reset: m0 first, then m1 after a gap
    m1_arvalid = 1'b1; m1_araddr = 32'h4000_0010; m1_rready = 1'b1;
    do_read(1'b0, 32'h8000_0004, 32'h1111_2222, RESP_OKAY, 1, 32'h1111_2222, 2'b00);
    chk("rr_gap", {31'd0, s_arvalid}, 32'd0);
    do_read(1'b1, 32'h4000_0010, 32'h3333_4444, RESP_OKAY, 1, 32'h3333_4444, 2'b00);

    for (int i = 0; i < 5; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, vecs[i].resp, vecs[i].lat, vecs[i].exp_resp);
      else
        do_read(vecs[i].m, vecs[i].addr, vecs[i].data, vecs[i].resp, vecs[i].lat,
                vecs[i].exp_data, vecs[i].exp_resp);
    end

    // last grant was m0 -> contention now goes to m1 first
    m0_arvalid = 1'b1; m0_araddr = 32'h8000_0020; m0_rready = 1'b1;
    do_read(1'b1, 32'h5000_0000, 32'h5555_0000, RESP_OKAY, 2, 32'h5555_0000, 2'b00);
    do_read(1'b0, 32'h8000_0020, 32'h0000_0020, RESP_OKAY, 1, 32'h0000_0020, 2'b00);

    // m1 write and read together: write wins, read follows
    m1_arvalid = 1'b1; m1_araddr = 32'h6000_0000; m1_rready = 1'b1;
    do_write(32'h6000_0004, 32'hA5A5_5A5A, 4'b1100, RESP_OKAY, 1, 2'b00);
    do_read(1'b1, 32'h6000_0000, 32'h0BAD_CAFE, RESP_OKAY, 1, 32'h0BAD_CAFE, 2'b00);

    // reset between AR and R handshakes of an m1 read
    m1_arvalid = 1'b1; m1_araddr = 32'h7000_0000; m1_rready = 1'b1;
    @(negedge clk);
    s_arready = 1'b1;
    #1 chk("rst_ar_hs", {31'd0, m1_arready}, 32'd1);
    @(negedge clk);
    s_arready = 1'b0; m1_arvalid = 1'b0;
    #1 chk("rst_in_rd1", {30'd0, dut.state_q}, {30'd0, ST_RD1});
    rst = 1'b1;
    @(negedge clk);
    s_rvalid = 1'b1;
    #1 chk_quiet("rst_mid_quiet");
    chk("rst_mid_idle", {30'd0, dut.state_q}, {30'd0, ST_IDLE});
    rst = 1'b0; s_rvalid = 1'b0;
    @(negedge clk);
    #1 chk_quiet("rst_after_quiet");
    do_read(1'b0, 32'h8000_0008, 32'h0000_0097, RESP_OKAY, 2, 32'h0000_0097, 2'b00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
